// File: rtl/led_pattern_pkg.sv
// Shared types for the LED pattern generator: channel modes and the per-channel configuration word.
package led_pattern_pkg;

    localparam int PERIOD_BITS = 16;
    localparam int LEVEL_BITS  = 16;

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        ON      = 2'd1,
        BLINK   = 2'd2,
        BREATHE = 2'd3
    } mode_t;

    typedef struct packed {
        mode_t                  mode;
        logic [PERIOD_BITS-1:0] period;
        logic [LEVEL_BITS-1:0]  level;
    } channel_cfg_t;

    // Terminal step count; a period of 0 behaves like 1.
    function automatic logic [PERIOD_BITS-1:0] period_last(input logic [PERIOD_BITS-1:0] period);
        return (period == '0) ? '0 : period - PERIOD_BITS'(1);
    endfunction

endpackage

// File: rtl/led_channel.sv
// Per-channel pattern engine: step counter, blink phase and breathe ramp feeding a PWM compare.
// Latency: lit is combinational from registered state; a write takes effect on its own edge.
// Backpressure: none; a write strobe always wins over a coincident step.
module led_channel
    import led_pattern_pkg::*;
#(
    parameter int PWM_BITS       = 8,
    parameter int DEFAULT_PERIOD = 500
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                wr,
    input  channel_cfg_t        cfg,
    output logic                lit
);

    localparam logic [PWM_BITS-1:0]   PWM_FULL = '1;
    localparam logic [LEVEL_BITS-1:0] FULL     = LEVEL_BITS'(PWM_FULL);

    channel_cfg_t           cfg_q;
    logic [PERIOD_BITS-1:0] step_cnt;
    logic                   phase;
    logic                   dir_down;
    logic [LEVEL_BITS-1:0]  bright;
    logic [LEVEL_BITS-1:0]  duty;
    logic                   step;

    assign step = tick && (step_cnt == period_last(cfg_q.period));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cfg_q    <= '{mode: BLINK, period: PERIOD_BITS'(DEFAULT_PERIOD), level: FULL};
            step_cnt <= '0;
            phase    <= 1'b0;
            dir_down <= 1'b0;
            bright   <= '0;
        end else if (wr) begin
            cfg_q    <= cfg;
            step_cnt <= '0;
            phase    <= 1'b0;
            dir_down <= 1'b0;
            bright   <= '0;
        end else if (step) begin
            step_cnt <= '0;
            phase    <= ~phase;
            // Ramp turns around by holding one step at each end.
            if (!dir_down) begin
                if (bright == cfg_q.level) dir_down <= 1'b1;
                else                       bright   <= bright + LEVEL_BITS'(1);
            end else begin
                if (bright == '0) dir_down <= 1'b0;
                else              bright   <= bright - LEVEL_BITS'(1);
            end
        end else if (tick) begin
            step_cnt <= step_cnt + PERIOD_BITS'(1);
        end
    end

    always_comb begin
        duty = '0;
        case (cfg_q.mode)
            OFF:     duty = '0;
            ON:      duty = cfg_q.level;
            BLINK:   duty = phase ? cfg_q.level : '0;
            BREATHE: duty = bright;
            default: duty = '0;
        endcase
        lit = (duty == FULL) || (LEVEL_BITS'(pwm_cnt) < duty);
    end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared prescaler and PWM counter, one engine per LED.
// Latency: led_out is registered one cycle after channel state; a config write shows on led_out the edge after accept.
// Backpressure: cfg_ready drops for one cycle after each accepted write (max one write per two cycles).
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int CLOCK_HZ       = 12_000_000,
    parameter int NUMBER_OF_LEDS = 8,
    parameter int TICK_HZ        = 1000,
    parameter int PWM_BITS       = 8,
    parameter int DEFAULT_PERIOD = 500,
    localparam int IDX_W         = (NUMBER_OF_LEDS > 1) ? $clog2(NUMBER_OF_LEDS) : 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [IDX_W-1:0]          cfg_index,
    input  logic [1:0]                cfg_mode,
    input  logic [PERIOD_BITS-1:0]    cfg_period,
    input  logic [PWM_BITS-1:0]       cfg_level,
    output logic [NUMBER_OF_LEDS-1:0] led_out,
    output logic                      tick_out
);

    localparam int TICK_DIV = CLOCK_HZ / TICK_HZ;
    localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    if (TICK_DIV < 1) begin : g_bad_tick_div
        $error("led_pattern_gen: CLOCK_HZ / TICK_HZ must be at least 1");
    end
    if (PWM_BITS > LEVEL_BITS) begin : g_bad_pwm_bits
        $error("led_pattern_gen: PWM_BITS wider than the configured level field");
    end

    logic [PRE_W-1:0]          pre_cnt;
    logic [PWM_BITS-1:0]       pwm_cnt;
    logic                      running;
    logic                      tick;
    logic                      accept;
    logic [NUMBER_OF_LEDS-1:0] lit;
    channel_cfg_t              cfg_in;

    // running keeps tick low through reset even when TICK_DIV is 1.
    assign tick     = running && (pre_cnt == PRE_LAST);
    assign tick_out = tick;
    assign accept   = cfg_valid && cfg_ready;
    assign cfg_in   = '{mode: mode_t'(cfg_mode), period: cfg_period, level: LEVEL_BITS'(cfg_level)};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt   <= '0;
            pwm_cnt   <= '0;
            running   <= 1'b0;
            cfg_ready <= 1'b0;
            led_out   <= '0;
        end else begin
            pre_cnt   <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PRE_W'(1);
            pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
            running   <= 1'b1;
            cfg_ready <= ~accept;
            led_out   <= lit;
        end
    end

    // Out-of-range indices match no channel, so they are accepted without effect.
    for (genvar i = 0; i < NUMBER_OF_LEDS; i++) begin : g_ch
        led_channel #(
            .PWM_BITS       (PWM_BITS),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_channel (
            .clock   (clock),
            .reset_n (reset_n),
            .tick    (tick),
            .pwm_cnt (pwm_cnt),
            .wr      (accept && (cfg_index == IDX_W'(i))),
            .cfg     (cfg_in),
            .lit     (lit[i])
        );
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: 8-channel and 5-channel instances at TICK_DIV=10, PWM_BITS=4, DEFAULT_PERIOD=2.
`timescale 1ns/1ps
module tb_led_pattern_gen;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_valid5 = 1'b0;
    logic [2:0]  cfg_index = '0;
    logic [1:0]  cfg_mode = '0;
    logic [15:0] cfg_period = '0;
    logic [3:0]  cfg_level = '0;
    logic        cfg_ready, cfg_ready5;
    logic [7:0]  led_out;
    logic [4:0]  led_out5;
    logic        tick_out, tick_out5;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    string name_q[$];
    int    val_q[$];

    always #5 clock = ~clock;

    // cyc equals k after the k-th rising edge since the last reset release.
    always @(posedge clock or negedge reset_n)
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;

    led_pattern_gen #(
        .CLOCK_HZ(1000), .NUMBER_OF_LEDS(8), .TICK_HZ(100), .PWM_BITS(4), .DEFAULT_PERIOD(2)
    ) u_dut (
        .clock(clock), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_index(cfg_index), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
        .cfg_level(cfg_level), .led_out(led_out), .tick_out(tick_out)
    );

    led_pattern_gen #(
        .CLOCK_HZ(1000), .NUMBER_OF_LEDS(5), .TICK_HZ(100), .PWM_BITS(4), .DEFAULT_PERIOD(2)
    ) u_dut5 (
        .clock(clock), .reset_n(reset_n), .cfg_valid(cfg_valid5), .cfg_ready(cfg_ready5),
        .cfg_index(cfg_index), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
        .cfg_level(cfg_level), .led_out(led_out5), .tick_out(tick_out5)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic sb_push(input string name, input int val);
        name_q.push_back(name);
        val_q.push_back(val);
    endtask

    task automatic sb_pop_check(input int act);
        if (val_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got %0d, expected a queued value", act);
        end else begin
            chk(name_q.pop_front(), act, val_q.pop_front());
        end
    endtask

    // Tick edges are rising edges e with e%10==0; count those in (w, j].
    function automatic int nticks(input int j, input int w);
        return (j >= w) ? (j / 10 - w / 10) : 0;
    endfunction

    // Blink output seen after edge k for a channel (re)started at edge w with period p.
    function automatic logic blink_exp(input int k, input int w, input int p);
        return ((nticks(k - 1, w) / p) % 2) == 1;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (cfg_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (cfg_ready !== 1'b1) chk("ready_timeout", cfg_ready, 1);
    endtask

    // Called at a negedge; returns at the negedge after the accept edge w.
    task automatic cfg_write(input int idx, input int mode, input int period, input int level, output int w);
        wait_ready();
        cfg_index  = 3'(idx);
        cfg_mode   = 2'(mode);
        cfg_period = 16'(period);
        cfg_level  = 4'(level);
        cfg_valid  = 1'b1;
        @(negedge clock);
        w = cyc;
        cfg_valid = 1'b0;
    endtask

    // Positions the bench so the next rising edge is a step edge of a period-2 blink channel.
    task automatic wait_step_slot();
        int n = 0;
        while (!((cyc % 20 == 19) && cfg_ready === 1'b1) && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (n >= 60) chk("step_slot_timeout", cyc % 20, 19);
    endtask

    typedef struct {int level; int exp_cnt;} on_vec_t;
    typedef struct {int idx; int mode; int level;} hs_vec_t;

    initial begin
        on_vec_t on_tab[4];
        hs_vec_t hs_tab[6];
        int      bseq[10];
        int      w, cnt, acc, j, duty;

        on_tab[0] = '{4, 4};
        on_tab[1] = '{15, 16};
        on_tab[2] = '{0, 0};
        on_tab[3] = '{9, 9};
        hs_tab[0] = '{4, 1, 15};
        hs_tab[1] = '{5, 0, 0};
        hs_tab[2] = '{7, 0, 0};
        hs_tab[3] = '{6, 0, 0};
        hs_tab[4] = '{7, 1, 15};
        hs_tab[5] = '{4, 0, 0};
        bseq = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 1};

        // Reset values, then asynchronous reset in the middle of a blink.
        repeat (3) @(negedge clock);
        chk("rst_led", led_out, 0);
        chk("rst_ready", cfg_ready, 0);
        chk("rst_tick", tick_out, 0);
        reset_n = 1'b1;
        repeat (30) @(negedge clock);
        chk("blink_on_before_reset", led_out, 8'hFF);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_led", led_out, 0);
        chk("async_rst_ready", cfg_ready, 0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("ready_low_at_release", cfg_ready, 0);
        @(negedge clock);
        chk("ready_first_edge", cfg_ready, 1);
        for (int i = 0; i < 84; i++) begin
            chk("default_blink", led_out, blink_exp(cyc, 0, 2) ? 8'hFF : 8'h00);
            @(negedge clock);
        end

        // ON mode duty cycles on channel 0.
        for (int i = 0; i < 4; i++) begin
            cfg_write(0, 1, 1, on_tab[i].level, w);
            sb_push($sformatf("on_highs_level%0d", on_tab[i].level), on_tab[i].exp_cnt);
            repeat (3) @(negedge clock);
            cnt = 0;
            for (int c = 0; c < 16; c++) begin
                cnt += int'(led_out[0]);
                @(negedge clock);
            end
            sb_pop_check(cnt);
        end

        // BLINK on channel 3, period 3; tick cadence.
        cfg_write(3, 2, 3, 15, w);
        @(negedge clock);
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            chk("blink_ch3", led_out[3], blink_exp(cyc, w, 3));
            chk("tick_out", tick_out, (cyc % 10) == 9);
        end

        // BREATHE on channel 1, period 1, peak 3; PWM phase follows cyc.
        cfg_write(1, 3, 1, 3, w);
        @(negedge clock);
        for (int i = 0; i < 88; i++) begin
            @(negedge clock);
            j    = cyc - 1;
            duty = bseq[nticks(j, w)];
            chk($sformatf("breathe_ch1_step%0d", nticks(j, w)), led_out[1], (j % 16) < duty);
        end

        // Back-to-back valid for six cycles: only alternate cycles are accepted.
        wait_ready();
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("hs_ready_%0d", i), cfg_ready, (i % 2) == 0);
            acc += (cfg_ready === 1'b1) ? 1 : 0;
            cfg_index  = 3'(hs_tab[i].idx);
            cfg_mode   = 2'(hs_tab[i].mode);
            cfg_level  = 4'(hs_tab[i].level);
            cfg_period = 16'd2;
            cfg_valid  = 1'b1;
            @(negedge clock);
        end
        cfg_valid = 1'b0;
        chk("hs_accept_count", acc, 3);
        chk("hs_ready_after", cfg_ready, 1);
        repeat (2) @(negedge clock);
        for (int i = 0; i < 40; i++) begin
            chk("hs_ch4_on", led_out[4], 1);
            chk("hs_ch7_on", led_out[7], 1);
            chk("hs_ch5_untouched", led_out[5], blink_exp(cyc, 0, 2));
            chk("hs_ch6_untouched", led_out[6], blink_exp(cyc, 0, 2));
            @(negedge clock);
        end

        // Out-of-range index on the 5-channel instance: handshake as usual, LEDs untouched.
        for (int r = 0; r < 2; r++) begin
            cfg_index  = (r == 0) ? 3'd7 : 3'd5;
            cfg_mode   = 2'd0;
            cfg_period = 16'd1;
            cfg_level  = 4'd0;
            cfg_valid5 = 1'b1;
            chk("oor_ready_before", cfg_ready5, 1);
            @(negedge clock);
            cfg_valid5 = 1'b0;
            chk("oor_ready_drop", cfg_ready5, 0);
            @(negedge clock);
            chk("oor_ready_back", cfg_ready5, 1);
        end
        for (int i = 0; i < 40; i++) begin
            chk("oor_led_unchanged", led_out5, blink_exp(cyc, 0, 2) ? 5'h1F : 5'h00);
            chk("oor_tick", tick_out5, (cyc % 10) == 9);
            @(negedge clock);
        end

        // Write to channel 2 (BLINK -> OFF) on the edge of its step.
        wait_step_slot();
        cfg_write(2, 0, 2, 15, w);
        chk("step_edge_alignment", w % 20, 0);
        chk("ch2_before_write", led_out[2], blink_exp(w, 0, 2));
        @(negedge clock);
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            chk("ch2_off_after_write", led_out[2], 0);
        end

        // Rewrite channel 5 with BLINK on its step edge: the step is dropped, phase restarts off.
        wait_step_slot();
        cfg_write(5, 2, 2, 15, w);
        @(negedge clock);
        for (int i = 0; i < 45; i++) begin
            @(negedge clock);
            chk("ch5_restart_blink", led_out[5], blink_exp(cyc, w, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
